// File: rtl/mp_regfile.sv
// Multi-ported register file: two write ports, NRD read ports, optional write-to-read
// forwarding, registered read option and a per-register busy scoreboard.
module mp_regfile #(
    parameter int DW        = 32,
    parameter int AW        = 5,
    parameter int NRD       = 2,
    parameter int BYPASS    = 1,
    parameter int R0_ZERO   = 1,
    parameter int SYNC_READ = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we0,
    input  logic              we1,
    input  logic [AW-1:0]     waddr0,
    input  logic [AW-1:0]     waddr1,
    input  logic [DW-1:0]     wdata0,
    input  logic [DW-1:0]     wdata1,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD*DW-1:0] rdata,
    output logic [NRD-1:0]    rbusy,
    input  logic              bset,
    input  logic [AW-1:0]     baddr,
    output logic              wconflict
);

    localparam int N = 1 << AW;

    logic [DW-1:0]     regQ [N];
    logic [N-1:0]      busyQ, busyD;
    logic              conflictQ;
    logic              wen0, wen1, setEn;
    logic [AW-1:0]     rdAddr [NRD];
    logic [DW-1:0]     readVal [NRD];
    logic [NRD*DW-1:0] rdataD;
    logic [NRD-1:0]    rbusyD;

    // A write is only "active" when it will really land: reset and register 0 mask it.
    always_comb begin
        wen0  = we0 && !reset && !(R0_ZERO != 0 && waddr0 == '0);
        wen1  = we1 && !reset && !(R0_ZERO != 0 && waddr1 == '0);
        setEn = bset && !(R0_ZERO != 0 && baddr == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) regQ[i] <= '0;
        end else begin
            if (wen0) regQ[waddr0] <= wdata0;
            if (wen1) regQ[waddr1] <= wdata1;
        end
    end

    // Set is applied after the clears so a new producer wins over a retiring write.
    always_comb begin
        busyD = busyQ;
        if (wen0)  busyD[waddr0] = 1'b0;
        if (wen1)  busyD[waddr1] = 1'b0;
        if (setEn) busyD[baddr]  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busyQ     <= '0;
            conflictQ <= 1'b0;
        end else begin
            busyQ     <= busyD;
            conflictQ <= we0 && we1 && (waddr0 == waddr1);
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_addr
        assign rdAddr[k]             = raddr[k*AW +: AW];
        assign rdataD[k*DW +: DW]    = readVal[k];
    end

    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            readVal[k] = regQ[rdAddr[k]];
            rbusyD[k]  = busyQ[rdAddr[k]];
            if (BYPASS != 0) begin
                if (wen1 && waddr1 == rdAddr[k]) begin
                    readVal[k] = wdata1;
                end else if (wen0 && waddr0 == rdAddr[k]) begin
                    readVal[k] = wdata0;
                end
                if (((wen0 && waddr0 == rdAddr[k]) || (wen1 && waddr1 == rdAddr[k]))
                    && !(setEn && baddr == rdAddr[k])) begin
                    rbusyD[k] = 1'b0;
                end
            end
            if (R0_ZERO != 0 && rdAddr[k] == '0) readVal[k] = '0;
        end
    end

    if (SYNC_READ != 0) begin : g_sync
        logic [NRD*DW-1:0] rdataQ;
        logic [NRD-1:0]    rbusyQ;

        always_ff @(posedge clk) begin
            if (reset) begin
                rdataQ <= '0;
                rbusyQ <= '0;
            end else begin
                rdataQ <= rdataD;
                rbusyQ <= rbusyD;
            end
        end

        assign rdata = rdataQ;
        assign rbusy = rbusyQ;
    end else begin : g_comb
        assign rdata = rdataD;
        assign rbusy = rbusyD;
    end

    assign wconflict = conflictQ;

endmodule

// File: tb/tb_mp_regfile.sv
// Scoreboard bench for mp_regfile: three configurations share write/scoreboard inputs and
// are checked against one array-based reference model of the register file.
module tb_mp_regfile;

    logic        clk = 1'b0;
    logic        reset, we0, we1, bset;
    logic [4:0]  waddr0, waddr1, baddr;
    logic [31:0] wdata0, wdata1;
    logic [9:0]  raddrAB;
    logic [19:0] raddrC;
    logic [63:0] rdataA, rdataB;
    logic [127:0] rdataC;
    logic [1:0]  rbusyA, rbusyB;
    logic [3:0]  rbusyC;
    logic        wconfA, wconfB, wconfC;

    always #5 clk = ~clk;

    mp_regfile #(.DW(32), .AW(5), .NRD(2), .BYPASS(1), .R0_ZERO(1), .SYNC_READ(0)) dutA (
        .clk(clk), .reset(reset), .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
        .wdata0(wdata0), .wdata1(wdata1), .raddr(raddrAB), .rdata(rdataA), .rbusy(rbusyA),
        .bset(bset), .baddr(baddr), .wconflict(wconfA));

    mp_regfile #(.DW(32), .AW(5), .NRD(2), .BYPASS(0), .R0_ZERO(1), .SYNC_READ(0)) dutB (
        .clk(clk), .reset(reset), .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
        .wdata0(wdata0), .wdata1(wdata1), .raddr(raddrAB), .rdata(rdataB), .rbusy(rbusyB),
        .bset(bset), .baddr(baddr), .wconflict(wconfB));

    mp_regfile #(.DW(32), .AW(5), .NRD(4), .BYPASS(1), .R0_ZERO(1), .SYNC_READ(1)) dutC (
        .clk(clk), .reset(reset), .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
        .wdata0(wdata0), .wdata1(wdata1), .raddr(raddrC), .rdata(rdataC), .rbusy(rbusyC),
        .bset(bset), .baddr(baddr), .wconflict(wconfC));

    typedef struct {
        int          due;
        int          dut;
        int          port;
        int          kind;
        logic [31:0] data;
        logic        busy;
        string       name;
    } exp_t;

    exp_t        sbQ[$];
    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    logic [31:0] mdl [32];
    bit          busyM [32];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void pushExp(input int due, input int dut, input int port, input int kind,
                                    input logic [31:0] d, input logic b, input string name);
        exp_t e;
        e.due = due; e.dut = dut; e.port = port; e.kind = kind;
        e.data = d; e.busy = b; e.name = name;
        sbQ.push_back(e);
    endfunction

    // Reference read: register 0 is zero, otherwise newest in-flight write then the array.
    function automatic logic [31:0] expRead(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && !reset && we1 && waddr1 == a) return wdata1;
        if (byp && !reset && we0 && waddr0 == a) return wdata0;
        return mdl[a];
    endfunction

    function automatic logic expBusy(input logic [4:0] a, input bit byp);
        bit beingWritten;
        beingWritten = !reset && a != 5'd0 && ((we0 && waddr0 == a) || (we1 && waddr1 == a));
        if (byp && beingWritten && !(bset && baddr == a)) return 1'b0;
        return busyM[a];
    endfunction

    task automatic checkOutput(input exp_t e);
        logic [31:0] gotD;
        logic        gotB;
        if (e.due != cyc) begin
            checks++;
            $display("[TB] FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.due);
            return;
        end
        if (e.kind == 1) begin
            gotB = (e.dut == 0) ? wconfA : (e.dut == 1) ? wconfB : wconfC;
            checks++;
            if (gotB === e.busy) passes++;
            else $display("[TB] FAIL %s dut%0d: wconflict got %b expected %b", e.name, e.dut, gotB, e.busy);
        end else begin
            case (e.dut)
                0:       begin gotD = rdataA[e.port*32 +: 32]; gotB = rbusyA[e.port]; end
                1:       begin gotD = rdataB[e.port*32 +: 32]; gotB = rbusyB[e.port]; end
                default: begin gotD = rdataC[e.port*32 +: 32]; gotB = rbusyC[e.port]; end
            endcase
            checks++;
            if (gotD === e.data) passes++;
            else $display("[TB] FAIL %s dut%0d port%0d: rdata got %h expected %h",
                          e.name, e.dut, e.port, gotD, e.data);
            checks++;
            if (gotB === e.busy) passes++;
            else $display("[TB] FAIL %s dut%0d port%0d: rbusy got %b expected %b",
                          e.name, e.dut, e.port, gotB, e.busy);
        end
    endtask

    // Monitor: compare every scoreboard entry whose observation cycle has arrived.
    always @(negedge clk) begin
        for (int i = sbQ.size() - 1; i >= 0; i--) begin
            if (sbQ[i].due <= cyc) begin
                checkOutput(sbQ[i]);
                sbQ.delete(i);
            end
        end
    end

    task automatic applyStimulus(input bit rst, input bit chk,
                                 input bit w0, input logic [4:0] a0, input logic [31:0] d0,
                                 input bit w1, input logic [4:0] a1, input logic [31:0] d1,
                                 input bit bs, input logic [4:0] ba,
                                 input logic [9:0] rab, input logic [19:0] rc);
        logic [4:0] a;
        bit         conf;
        @(posedge clk);
        #1;
        reset = rst; we0 = w0; waddr0 = a0; wdata0 = d0;
        we1 = w1; waddr1 = a1; wdata1 = d1; bset = bs; baddr = ba;
        raddrAB = rab; raddrC = rc;
        if (chk) begin
            for (int k = 0; k < 2; k++) begin
                a = rab[k*5 +: 5];
                pushExp(cyc, 0, k, 0, expRead(a, 1'b1), expBusy(a, 1'b1), "combBypass");
                pushExp(cyc, 1, k, 0, expRead(a, 1'b0), expBusy(a, 1'b0), "combNoBypass");
            end
            for (int k = 0; k < 4; k++) begin
                a = rc[k*5 +: 5];
                pushExp(cyc + 1, 2, k, 0, rst ? 32'd0 : expRead(a, 1'b1),
                        rst ? 1'b0 : expBusy(a, 1'b1), "syncRead");
            end
            conf = !rst && w0 && w1 && (a0 == a1);
            for (int d = 0; d < 3; d++) pushExp(cyc + 1, d, 0, 1, 32'd0, conf, "wconflict");
        end
        if (rst) begin
            for (int i = 0; i < 32; i++) begin mdl[i] = 32'd0; busyM[i] = 1'b0; end
        end else begin
            if (w0 && a0 != 5'd0) begin mdl[a0] = d0; busyM[a0] = 1'b0; end
            if (w1 && a1 != 5'd0) begin mdl[a1] = d1; busyM[a1] = 1'b0; end
            if (bs && ba != 5'd0) busyM[ba] = 1'b1;
        end
    endtask

    task automatic idle(input logic [9:0] rab, input logic [19:0] rc);
        applyStimulus(0, 1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, rab, rc);
    endtask

    function automatic void expectConst(input int dut, input int port, input logic [31:0] d,
                                        input logic b, input string name);
        pushExp(cyc, dut, port, 0, d, b, name);
    endfunction

    function automatic logic [4:0] randAddr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        reset = 1'b1; we0 = 0; we1 = 0; bset = 0;
        waddr0 = '0; waddr1 = '0; baddr = '0; wdata0 = '0; wdata1 = '0;
        raddrAB = '0; raddrC = '0;
        for (int i = 0; i < 32; i++) begin mdl[i] = 32'd0; busyM[i] = 1'b0; end

        applyStimulus(1, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, '0, '0);
        applyStimulus(1, 1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, {5'd7, 5'd5}, '0);
        expectConst(0, 0, 32'd0, 1'b0, "resetRead");
        expectConst(1, 1, 32'd0, 1'b0, "resetRead");

        applyStimulus(0, 1, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 0, 5'd0,
                      {5'd0, 5'd5}, {5'd5, 5'd5, 5'd5, 5'd5});
        expectConst(0, 0, 32'hDEADBEEF, 1'b0, "bypassR5");
        expectConst(1, 0, 32'd0, 1'b0, "noBypassR5Old");
        idle({5'd0, 5'd5}, {5'd5, 5'd5, 5'd5, 5'd5});
        expectConst(0, 0, 32'hDEADBEEF, 1'b0, "readR5");
        expectConst(1, 0, 32'hDEADBEEF, 1'b0, "readR5");
        expectConst(2, 0, 32'hDEADBEEF, 1'b0, "syncR5");

        applyStimulus(0, 1, 1, 5'd7, 32'h11111111, 1, 5'd7, 32'h22222222, 0, 5'd0,
                      {5'd7, 5'd0}, '0);
        expectConst(0, 1, 32'h22222222, 1'b0, "dualWriteBypass");
        idle({5'd7, 5'd0}, '0);
        pushExp(cyc, 0, 0, 1, 32'd0, 1'b1, "conflictSet");
        expectConst(0, 1, 32'h22222222, 1'b0, "port1Priority");
        expectConst(1, 1, 32'h22222222, 1'b0, "port1Priority");
        idle('0, '0);
        pushExp(cyc, 0, 0, 1, 32'd0, 1'b0, "conflictClear");
        pushExp(cyc, 2, 0, 1, 32'd0, 1'b0, "conflictClear");

        applyStimulus(0, 1, 1, 5'd3, 32'h12345678, 0, 5'd0, 32'd0, 0, 5'd0, {5'd0, 5'd3}, '0);
        expectConst(0, 0, 32'h12345678, 1'b0, "bypassR3");
        expectConst(1, 0, 32'd0, 1'b0, "noBypassR3Old");
        idle({5'd0, 5'd3}, '0);
        expectConst(1, 0, 32'h12345678, 1'b0, "noBypassR3New");

        applyStimulus(0, 1, 1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'd0, 1, 5'd0, {5'd0, 5'd0}, '0);
        expectConst(0, 0, 32'd0, 1'b0, "r0BypassZero");
        idle({5'd0, 5'd0}, '0);
        expectConst(0, 0, 32'd0, 1'b0, "r0Zero");
        expectConst(1, 0, 32'd0, 1'b0, "r0Zero");

        applyStimulus(0, 1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd9, {5'd0, 5'd9}, '0);
        expectConst(0, 0, 32'd0, 1'b0, "busyBeforeSet");
        idle({5'd0, 5'd9}, '0);
        expectConst(0, 0, 32'd0, 1'b1, "busySet");
        expectConst(1, 0, 32'd0, 1'b1, "busySet");
        applyStimulus(0, 1, 1, 5'd9, 32'h55AA55AA, 0, 5'd0, 32'd0, 1, 5'd9, {5'd0, 5'd9}, '0);
        expectConst(0, 0, 32'h55AA55AA, 1'b1, "writeAndSetSame");
        idle({5'd0, 5'd9}, '0);
        expectConst(0, 0, 32'h55AA55AA, 1'b1, "newProducerWins");
        expectConst(1, 0, 32'h55AA55AA, 1'b1, "newProducerWins");
        applyStimulus(0, 1, 1, 5'd9, 32'h0A0A0A0A, 0, 5'd0, 32'd0, 0, 5'd0, {5'd0, 5'd9}, '0);
        expectConst(0, 0, 32'h0A0A0A0A, 1'b0, "writeClearsForward");
        expectConst(1, 0, 32'h55AA55AA, 1'b1, "writeClearsNoForward");
        idle({5'd0, 5'd9}, '0);
        expectConst(0, 0, 32'h0A0A0A0A, 1'b0, "busyCleared");
        expectConst(1, 0, 32'h0A0A0A0A, 1'b0, "busyCleared");

        for (int i = 0; i < 10000; i++) begin
            bit          rst, w0, w1, bs;
            logic [4:0]  a0, a1, ba;
            logic [9:0]  rab;
            logic [19:0] rc;
            rst = (i == 5000 || i == 5001);
            w0 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
            bs = ($urandom_range(0, 3) == 0);
            a0 = randAddr(); a1 = randAddr(); ba = randAddr();
            rab = {randAddr(), randAddr()};
            rc = {randAddr(), randAddr(), randAddr(), randAddr()};
            if (i == 5002) begin w0 = 0; w1 = 0; bs = 0; end
            applyStimulus(rst, 1, w0, a0, $urandom, w1, a1, $urandom, bs, ba, rab, rc);
            if (i == 5001) begin
                expectConst(0, 0, 32'd0, 1'b0, "readAfterReset");
                expectConst(0, 1, 32'd0, 1'b0, "readAfterReset");
            end
            if (i == 5003) begin
                for (int k = 0; k < 4; k++) expectConst(2, k, 32'd0, 1'b0, "syncReadAfterReset");
            end
        end

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sbQ.size() == 0) passes++;
        else $display("[TB] FAIL scoreboardDrain: %0d entries left, expected 0", sbQ.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mp_regfile.md
MP_REGFILE -- requirements
Module: mp_regfile

Interface
REQ-001 SHALL have parameter DW, default 32, data width in bits.
REQ-002 SHALL have parameter AW, default 5, address width; register count N = 2**AW.
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter BYPASS, default 1, write-to-read forwarding enable.
REQ-005 SHALL have parameter R0_ZERO, default 1, register 0 hardwired to zero.
REQ-006 SHALL have parameter SYNC_READ, default 0, read latency (0 = combinational, 1 = registered).
REQ-007 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-008 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-009 SHALL have ports we0, we1  input  1 each  write enables, ports 0 and 1.
REQ-010 SHALL have ports waddr0, waddr1  input  AW each  write addresses.
REQ-011 SHALL have ports wdata0, wdata1  input  DW each  write data.
REQ-012 SHALL have port raddr  input  NRD*AW  packed read addresses, port k at bits [k*AW +: AW].
REQ-013 SHALL have port rdata  output  NRD*DW  packed read data, port k at bits [k*DW +: DW].
REQ-014 SHALL have port rbusy  output  NRD  scoreboard busy flag of each read address.
REQ-015 SHALL have ports bset, baddr  input  1, AW  scoreboard set request and address.
REQ-016 SHALL have port wconflict  output  1  registered flag: both write ports hit same address last cycle.

Function
REQ-017 SHALL store N registers of DW bits; writes take effect at the rising edge when weX=1 and reset=0.
REQ-018 SHALL, with R0_ZERO=1, ignore writes to address 0 and return 0 for reads of address 0, including bypass paths.
REQ-019 SHALL, when we0 and we1 target the same address in one cycle, store wdata1 (port 1 priority) and set wconflict to 1 in the next cycle, otherwise 0.
REQ-020 SHALL, with BYPASS=1 and SYNC_READ=0, return in the same cycle the data being written this cycle when raddr matches an active write address, port 1 data taking priority over port 0.
REQ-021 SHALL, with BYPASS=0, return only the stored array contents (new value visible the cycle after the write).
REQ-022 SHALL, with SYNC_READ=1, present rdata one cycle after raddr is sampled; with BYPASS=1 the sampled value includes same-edge writes (write-first).
REQ-023 SHALL keep an N-bit busy scoreboard: bset=1 sets busy[baddr]; an active write to address A clears busy[A].
REQ-024 SHALL, when bset and a write target the same address in one cycle, leave that bit set (new producer wins).
REQ-025 SHALL never set busy[0] when R0_ZERO=1.
REQ-026 SHALL drive rbusy[k] = busy[raddr_k] combinationally, forced 0 if the same address is being written this cycle and not simultaneously bset (with BYPASS=1); rbusy is registered alongside rdata when SYNC_READ=1.
REQ-027 SHALL produce no X on any output after the first reset cycle for any in-range input.

Reset
REQ-028 SHALL, on reset=1 at a rising edge, clear all registers, the busy scoreboard, wconflict and any SYNC_READ output registers to 0, overriding writes and bset in that cycle.
REQ-029 SHALL, if reset is asserted mid-operation, discard pending writes and busy bits in the same edge; first valid write is the edge after reset deasserts.

Verification
REQ-030 SHALL cover: reset, write 0xDEADBEEF to r5 via we0, read raddr port0=5 next cycle -> rdata0=0xDEADBEEF, rbusy0=0.
REQ-031 SHALL cover: we0 r7=0x11111111 and we1 r7=0x22222222 same cycle -> r7=0x22222222, wconflict=1 next cycle, 0 the cycle after.
REQ-032 SHALL cover: BYPASS=1, SYNC_READ=0, write r3=0x12345678 while reading r3 -> rdata=0x12345678 same cycle; BYPASS=0 -> old value 0 until next cycle.
REQ-033 SHALL cover: write r0=0xFFFFFFFF and bset baddr=0 -> read r0=0, rbusy=0.
REQ-034 SHALL cover: bset r9, next cycle rbusy(r9)=1; write r9 with bset r9 same cycle -> stays 1; write r9 alone -> 0 next cycle.
REQ-035 SHALL cover: SYNC_READ=1, NRD=4, random writes/reads vs. reference model over 10000 cycles, reset asserted mid-run -> all reads 0 after reset.
